// File: rtl/pio_input_irq.sv
// Avalon-MM input PIO for board switches/buttons: two-flop synchroniser, per-bit
// debounce filter, write-1-to-clear edge capture and a maskable level interrupt.
`timescale 1ns/1ps

module pio_input_irq #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } addr_e;

    logic [WIDTH-1:0]          r_s1;
    logic [WIDTH-1:0]          r_s2;
    logic [WIDTH-1:0]          r_filt;
    logic [WIDTH-1:0][CW-1:0]  r_cnt;
    logic [WIDTH-1:0]          r_mask;
    logic [WIDTH-1:0]          r_edge;

    logic [WIDTH-1:0]          w_filt_next;
    logic [WIDTH-1:0][CW-1:0]  w_cnt_next;
    logic [WIDTH-1:0]          w_commit;
    logic [WIDTH-1:0]          w_set;
    logic [WIDTH-1:0]          w_clr;
    logic [WIDTH-1:0]          w_mask_next;
    logic [WIDTH-1:0]          w_edge_next;
    logic [31:0]               w_rdata;
    logic                      w_wr;
    addr_e                     w_addr;
    logic                      w_unused;

    assign w_addr   = addr_e'(address);
    assign w_wr     = chipselect & ~write_n;
    // Upper write-data bits beyond WIDTH have no destination.
    assign w_unused = ^writedata;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_filt_next = r_filt;
        w_cnt_next  = r_cnt;
        w_commit    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] == r_filt[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_filt_next[i] = r_s2[i];
                w_cnt_next[i]  = '0;
                w_commit[i]    = 1'b1;
            end else begin
                w_cnt_next[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    always_comb begin
        w_set = '0;
        case (EDGE_TYPE)
            0:       w_set = w_commit & r_s2;
            1:       w_set = w_commit & ~r_s2;
            default: w_set = w_commit;
        endcase
    end

    // A capture arriving on the same cycle as its clear is kept.
    assign w_clr       = (w_wr && w_addr == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign w_edge_next = (r_edge & ~w_clr) | w_set;
    assign w_mask_next = (w_wr && w_addr == ADDR_MASK) ? writedata[WIDTH-1:0] : r_mask;

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_DATA: w_rdata[WIDTH-1:0] = r_filt;
            ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rdata[WIDTH-1:0] = r_edge;
            default:   w_rdata = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the per-bit counters are plain flops, so they are reset along with everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_filt   <= '0;
            r_cnt    <= '0;
            r_mask   <= '0;
            r_edge   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            r_s1     <= in_port;
            r_s2     <= r_s1;
            r_filt   <= w_filt_next;
            r_cnt    <= w_cnt_next;
            r_mask   <= w_mask_next;
            r_edge   <= w_edge_next;
            readdata <= w_rdata;
            irq      <= |(w_edge_next & w_mask_next);
        end
    end

endmodule

// File: tb/tb_pio_input_irq.sv
// Directed bench for pio_input_irq: one instance per edge type sharing all inputs.
`timescale 1ns/1ps

module tb_pio_input_irq;

    localparam int W = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_rise, rd_fall, rd_any;
    logic          irq_rise, irq_fall, irq_any;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pio_input_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_rise),
        .in_port(in_port), .irq(irq_rise)
    );

    pio_input_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_fall),
        .in_port(in_port), .irq(irq_fall)
    );

    pio_input_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_any),
        .in_port(in_port), .irq(irq_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves time 1ns after the n-th rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        #12;
        check("reset_readdata", rd_rise, 32'h0);
        check("reset_irq", {31'b0, irq_rise}, 32'h0);
        reset_n = 1'b1;
        tick(1);

        // Register map after reset, plus a write to the reserved word.
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            check($sformatf("read_addr%0d", a), rd_rise, 32'h0);
        end
        check("idle_irq", {31'b0, irq_rise}, 32'h0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check("rsvd_write_ignored", rd_rise, 32'h0);

        // Latency: pin sampled at edge k shows on readdata from edge k+6.
        address = 2'd0;
        tick(1);
        in_port = 10'h2A5;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check($sformatf("latency_pre_k%0d", i), rd_rise, 32'h0);
        end
        tick(1);
        check("latency_k6", rd_rise, 32'h2A5);
        bus_read(2'd3);
        check("edge_after_2a5", rd_rise, 32'h2A5);
        check("irq_masked", {31'b0, irq_rise}, 32'h0);

        in_port = '0;
        tick(8);
        bus_write(2'd3, 32'h3FF);
        bus_read(2'd0);
        check("cleanup_data", rd_rise, 32'h0);
        bus_read(2'd3);
        check("cleanup_edge", rd_rise, 32'h0);

        // Three-cycle glitch is rejected, four-cycle pulse is accepted.
        address = 2'd0;
        in_port = 10'h001;
        tick(3);
        in_port = 10'h000;
        tick(8);
        check("glitch_data", rd_rise, 32'h0);
        bus_read(2'd3);
        check("glitch_edge", rd_rise, 32'h0);

        address = 2'd0;
        in_port = 10'h001;
        tick(4);
        in_port = 10'h000;
        tick(3);
        check("pulse4_data", rd_rise, 32'h1);
        tick(10);
        bus_read(2'd3);
        check("pulse4_edge", rd_rise, 32'h1);

        // Interrupt: mask bit 0, raise bit 0, clear with W1C.
        bus_write(2'd3, 32'h3FF);
        bus_write(2'd2, 32'h001);
        bus_read(2'd2);
        check("mask_readback", rd_rise, 32'h1);
        in_port = 10'h001;
        tick(5);
        check("irq_before_commit", {31'b0, irq_rise}, 32'h0);
        tick(1);
        check("irq_on_capture", {31'b0, irq_rise}, 32'h1);
        bus_write(2'd3, 32'h002);
        check("irq_w1c_other_bit", {31'b0, irq_rise}, 32'h1);
        bus_write(2'd3, 32'h001);
        check("irq_w1c_cleared", {31'b0, irq_rise}, 32'h0);
        bus_read(2'd3);
        check("edge_after_w1c", rd_rise, 32'h0);

        // Clear of bit 3 on the very edge its rising edge commits.
        in_port = 10'h009;
        tick(5);
        bus_write(2'd3, 32'h008);
        bus_read(2'd3);
        check("set_beats_clear", rd_rise, 32'h8);
        check("irq_unmasked_bit3", {31'b0, irq_rise}, 32'h0);
        bus_write(2'd3, 32'h008);
        bus_read(2'd3);
        check("bit3_cleared", rd_rise, 32'h0);

        // Edge-type selection on bit 5.
        bus_write(2'd3, 32'h3FF);
        in_port = 10'h029;
        tick(8);
        bus_read(2'd3);
        check("rise_on_rise", rd_rise, 32'h20);
        check("fall_on_rise", rd_fall, 32'h00);
        check("any_on_rise",  rd_any,  32'h20);
        bus_write(2'd3, 32'h3FF);
        in_port = 10'h009;
        tick(8);
        bus_read(2'd3);
        check("rise_on_fall", rd_rise, 32'h00);
        check("fall_on_fall", rd_fall, 32'h20);
        check("any_on_fall",  rd_any,  32'h20);

        // Raise irq on the falling-edge instance so reset has something to clear.
        bus_write(2'd2, 32'h008);
        in_port = 10'h001;
        tick(8);
        check("irq_fall_bit3", {31'b0, irq_fall}, 32'h1);
        address = 2'd0;
        tick(1);
        check("pre_reset_data", rd_rise, 32'h001);

        // Reset with bit 9 mid-debounce (counter at 2).
        in_port = 10'h201;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", rd_rise, 32'h0);
        check("async_reset_irq", {31'b0, irq_fall}, 32'h0);
        #2;
        reset_n = 1'b1;
        tick(6);
        check("post_reset_pre", rd_rise, 32'h0);
        tick(1);
        check("post_reset_accept", rd_rise, 32'h201);
        bus_read(2'd2);
        check("post_reset_mask", rd_rise, 32'h0);
        bus_read(2'd3);
        check("powerup_edge", rd_rise, 32'h201);
        check("powerup_irq", {31'b0, irq_rise}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
